// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module : reg_arb_pkg
// Desc   : Shared types, constants and helpers for reg_load_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int MAX_N_REQ = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_LOAD = 3'b010,
        ST_ACK  = 3'b100
    } state_t;

    function automatic logic [MAX_N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Desc   : Combinational round-robin picker; search starts at ptr and wraps.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int               w_c;
    logic [PTR_W-1:0] w_cand;

    always_comb begin
        w_c    = 0;
        w_cand = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_c = int'(ptr) + k;
            if (w_c >= N_REQ) begin
                w_c = w_c - N_REQ;
            end
            w_cand = PTR_W'(w_c);
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
        gnt = any ? N_REQ'(idx_to_onehot(IDX_W'(idx))) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/reg_load_arbiter.sv
// ============================================================================
// Module : reg_load_arbiter
// Desc   : Round-robin req/ack arbiter steering one winner onto a shared
//          load-enabled register bank. Define ARB_LOCK_EN for bus-hold.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_load_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]       reg_q,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   reg_ld,
    output logic                   busy,
    output logic [WIDTH-1:0]       rdata
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_next;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_pick_gnt;
    logic [PTR_W-1:0] r_idx;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_pick_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_pick_any;
    logic             w_relock;
    logic [WIDTH-1:0] r_reg_d;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_wd [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_wd[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

`ifdef ARB_LOCK_EN
    assign w_relock = lock[r_idx] & req[r_idx];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_relock      = 1'b0;
`endif

    assign w_ptr_next = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_any) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_ACK;
            ST_ACK:  w_next = w_relock ? ST_LOAD : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant and data are latched with the decision so they stay stable while the bank loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_reg_d <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_gnt;
                        r_idx   <= w_pick_idx;
                        r_reg_d <= w_wd[w_pick_idx];
                    end
                end
                ST_ACK: begin
                    r_rdata <= reg_q;
                    if (w_relock) begin
                        r_reg_d <= w_wd[r_idx];
                    end else begin
                        r_gnt <= '0;
                        r_ptr <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign ack    = (r_state == ST_ACK) ? r_gnt : '0;
    assign reg_d  = r_reg_d;
    assign reg_ld = (r_state == ST_LOAD);
    assign busy   = (r_state != ST_IDLE);
    assign rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
// ============================================================================
// Module : tb_reg_load_arbiter
// Desc   : Scoreboard bench for reg_load_arbiter with an external bank model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_load_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N*W-1:0] wdata;
    logic [W-1:0] reg_q;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic [W-1:0] reg_d;
    logic         reg_ld;
    logic         busy;
    logic [W-1:0] rdata;
    logic [W-1:0] bank;

    reg_load_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .reg_q  (reg_q),
        .gnt    (gnt),
        .ack    (ack),
        .reg_d  (reg_d),
        .reg_ld (reg_ld),
        .busy   (busy),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register bank, cleared by the same reset.
    always @(posedge clk or posedge reset) begin
        if (reset) bank <= '0;
        else if (reg_ld) bank <= reg_d;
    end
    assign reg_q = bank;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         w;
        logic [7:0] data;
        int         ack_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a write occupies the arbiter for two cycles after the decision.
    int m_busy = 0;
    int m_ptr  = 0;
    int m_cur  = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
            exp_q.delete();
        end else if (m_busy == 0) begin
            if (req != '0) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_cur = c;
                    end
                end
                exp_q.push_back('{m_cur, wdata[m_cur*W +: W], cyc + 2});
                m_busy = 2;
            end
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else begin
            if (LOCK && lock[m_cur] && req[m_cur]) begin
                exp_q.push_back('{m_cur, wdata[m_cur*W +: W], cyc + 2});
                m_busy = 2;
            end else begin
                m_ptr  = (m_cur + 1) % N;
                m_busy = 0;
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_total++;
        if (act !== req_v) begin
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
        end else begin
            n_pass++;
        end
    endtask

    logic       rd_pend = 1'b0;
    logic [7:0] rd_exp  = '0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_gnt",    32'(gnt),    0);
            chk("rst_ack",    32'(ack),    0);
            chk("rst_reg_ld", 32'(reg_ld), 0);
            chk("rst_reg_d",  32'(reg_d),  0);
            chk("rst_busy",   32'(busy),   0);
            chk("rst_rdata",  32'(rdata),  0);
            rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                chk("rdata", 32'(rdata), 32'(rd_exp));
                rd_pend = 1'b0;
            end
            if (reg_ld) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_load", 32'(reg_ld), 0);
                end else begin
                    chk("load_gnt",   32'(gnt),  32'(1) << exp_q[0].w);
                    chk("load_reg_d", 32'(reg_d), 32'(exp_q[0].data));
                    chk("load_cycle", cyc, exp_q[0].ack_cyc - 1);
                    chk("load_busy",  32'(busy), 1);
                    chk("load_ack",   32'(ack),  0);
                end
            end else if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_ack", 32'(ack), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack",       32'(ack),  32'(1) << e.w);
                    chk("ack_gnt",   32'(gnt),  32'(1) << e.w);
                    chk("ack_cycle", cyc, e.ack_cyc);
                    chk("ack_busy",  32'(busy), 1);
                    rd_pend = 1'b1;
                    rd_exp  = e.data;
                end
            end else begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_gnt",  32'(gnt),  0);
                if (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
                    chk("ack_timeout", 32'(ack), 32'(1) << exp_q[0].w);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N-1:0] ack_prev;

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        hold(3);
        reset = 1'b0;

        // all requesters active, distinct data
        wdata = 32'h44332211;
        req   = 4'b1111;
        hold(15);
        req   = '0;
        hold(2);

        // single requester
        wdata = 32'h0000A500;
        req   = 4'b0010;
        hold(3);
        req   = '0;
        hold(2);

        // serve requester 2, then wrap-around between 3 and 0
        wdata = 32'h7E3C5AC3;
        req   = 4'b0100;
        hold(3);
        req   = 4'b1001;
        hold(6);
        req   = '0;
        hold(2);

        // reset asserted while requester 2 is loading
        wdata = 32'h005A0099;
        req   = 4'b0100;
        @(posedge clk);
        #2;
        reset = 1'b1;
        req   = 4'b0101;
        @(negedge clk);
        hold(1);
        reset = 1'b0;
        hold(3);
        req   = '0;
        hold(2);

        // lock held by requester 0 while 0 and 2 both request
        wdata = 32'h00C100B1;
        req   = 4'b0101;
        lock  = 4'b0001;
        hold(5);
        lock  = '0;
        hold(6);
        req   = '0;
        hold(6);

        // requester drops req during LOAD
        wdata = 32'h000000E7;
        req   = 4'b0001;
        hold(1);
        req   = '0;
        hold(5);

        // randomized traffic
        ack_prev = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            ack_prev = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack_prev[i]) begin
                        if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                        else wdata[i*W +: W] = 8'($urandom);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i]           = 1'b1;
                    wdata[i*W +: W] = 8'($urandom);
                end
            end
            lock = 4'($urandom);
        end
        req  = '0;
        lock = '0;
        hold(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
